// File: rtl/regfile_read_port_pkg.sv
// regfile_read_port_pkg: shared widths, zero-register index and response-flag encoding
package regfile_read_port_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX = 0;
  typedef enum logic {RSP_EMPTY = 1'b0, RSP_FULL = 1'b1} rsp_state_e;
endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: register storage, one synchronous write port, two async read ports, zero-register masking
module regfile_bank
  import regfile_read_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
    end else if (we && !(ZERO_REG != 0 && waddr == ZA)) begin
      mem_q[waddr] <= wdata;
    end
  end
  assign rd0 = (ZERO_REG != 0 && ra0 == ZA) ? '0 : mem_q[ra0];
  assign rd1 = (ZERO_REG != 0 && ra1 == ZA) ? '0 : mem_q[ra1];
endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: register bank with valid/ready operand reads and a registered one-cycle response.
// RF_BYPASS_EN enables same-cycle write forwarding and in-place refresh of stalled outputs.
module regfile_read_port
  import regfile_read_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);
  rsp_state_e state_q, state_d;
  logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d, rs_rd, rt_rd;
  logic accept, stall;
  regfile_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_bank (
    .clk(clk), .rst(rst), .we(wr_en), .waddr(wr_addr), .wdata(wr_data),
    .ra0(rs_addr), .ra1(rt_addr), .rd0(rs_rd), .rd1(rt_rd)
  );
  assign rsp_valid = state_q == RSP_FULL;
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept = req_valid && req_ready;
  assign stall = rsp_valid && !rsp_ready;
  assign rs_data = rs_q;
  assign rt_data = rt_q;
  always_comb state_d = accept ? RSP_FULL : (rsp_ready ? RSP_EMPTY : state_q);
`ifdef RF_BYPASS_EN
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);
  logic [ADDR_W-1:0] rs_idx_q, rs_idx_d, rt_idx_q, rt_idx_d;
  logic wr_live;
  assign wr_live = wr_en && !(ZERO_REG != 0 && wr_addr == ZA);
  // accept and stall are mutually exclusive, so capture and refresh never collide
  always_comb begin
    rs_idx_d = accept ? rs_addr : rs_idx_q;
    rt_idx_d = accept ? rt_addr : rt_idx_q;
    rs_d = accept ? ((wr_live && wr_addr == rs_addr) ? wr_data : rs_rd)
         : (stall && wr_live && wr_addr == rs_idx_q) ? wr_data : rs_q;
    rt_d = accept ? ((wr_live && wr_addr == rt_addr) ? wr_data : rt_rd)
         : (stall && wr_live && wr_addr == rt_idx_q) ? wr_data : rt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_idx_q <= '0;
      rt_idx_q <= '0;
    end else begin
      rs_idx_q <= rs_idx_d;
      rt_idx_q <= rt_idx_d;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall;
  always_comb begin
    rs_d = accept ? rs_rd : rs_q;
    rt_d = accept ? rt_rd : rt_q;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_EMPTY;
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      state_q <= state_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
    end
  end
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: table-driven check of reads, writes, zero register, bypass, stalls and reset
module tb_regfile_read_port;
`ifdef RF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic rv; logic [4:0] ra; logic [4:0] rb; logic rr;
    logic x_rdy; logic x_v; logic [31:0] x_rs; logic [31:0] x_rt;
  } vec_t;
  logic clk = 0, rst = 1, wr_en = 0, req_valid = 0, rsp_ready = 0;
  logic [4:0] wr_addr = 0, rs_addr = 0, rt_addr = 0;
  logic [31:0] wr_data = 0;
  logic req_ready, rsp_valid;
  logic [31:0] rs_data, rt_data;
  int total = 0, bad = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  regfile_read_port dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rs_data(rs_data), .rt_data(rt_data)
  );
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [4:0] ra, input logic [4:0] rb, input logic rr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    req_valid = rv; rs_addr = ra; rt_addr = rb; rsp_ready = rr;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_rsp(input string n, input logic v, input logic [31:0] xs, input logic [31:0] xt);
    check({n, " rsp_valid"}, 32'(rsp_valid), 32'(v));
    check({n, " rs_data"}, rs_data, xs);
    check({n, " rt_data"}, rt_data, xt);
  endtask
  function automatic void add(logic we, logic [4:0] wa, logic [31:0] wd, logic rv,
                              logic [4:0] ra, logic [4:0] rb, logic rr,
                              logic x_rdy, logic x_v, logic [31:0] x_rs, logic [31:0] x_rt);
    tbl.push_back('{we, wa, wd, rv, ra, rb, rr, x_rdy, x_v, x_rs, x_rt});
  endfunction
  initial begin
    add(0, 0, 0, 1, 3, 7, 1, 1, 1, 0, 0);
    add(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 5, 0, 1, 1, 1, 32'hDEADBEEF, 0);
    add(1, 0, 32'h1234, 1, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 5, 1, 1, 1, 0, 32'hDEADBEEF);
    add(1, 9, 32'hA5A5A5A5, 1, 9, 5, 1, 1, 1, BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF);
    add(0, 0, 0, 1, 9, 9, 1, 1, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    for (int k = 1; k <= 8; k++) add(1, 5'(k), 32'(k), 0, 0, 0, 1, 1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 5'(k), 5'(9 - k), 1, 1, 1, 32'(k), 32'(9 - k));
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 8, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    rst = 0;
    #1;
    check_rsp("reset", 0, 0, 0);
    check("reset req_ready", 32'(req_ready), 1);
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].rb, tbl[i].rr);
      #1;
      check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tbl[i].x_rdy));
      step();
      check_rsp($sformatf("vec%0d", i), tbl[i].x_v, tbl[i].x_rs, tbl[i].x_rt);
    end
    drive(1, 2, 32'h11, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 1, 2, 2, 0);
    #1 check("stall accept req_ready", 32'(req_ready), 1);
    step();
    check_rsp("stall c0", 1, 32'h11, 32'h11);
    drive(0, 0, 0, 1, 4, 4, 0);
    #1 check("stall c1 req_ready", 32'(req_ready), 0);
    step();
    check_rsp("stall c1", 1, 32'h11, 32'h11);
    drive(1, 2, 32'h22, 1, 4, 4, 0);
    #1 check("stall c2 req_ready", 32'(req_ready), 0);
    step();
    check_rsp("stall c2", 1, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11);
    drive(0, 0, 0, 1, 4, 4, 0);
    #1 check("stall c3 req_ready", 32'(req_ready), 0);
    step();
    check_rsp("stall c3", 1, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11);
    drive(0, 0, 0, 1, 4, 4, 1);
    #1 check("release req_ready", 32'(req_ready), 1);
    step();
    check_rsp("release", 1, 4, 4);
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    check_rsp("drain", 0, 4, 4);
    drive(0, 0, 0, 1, 2, 2, 1);
    step();
    check_rsp("reread r2", 1, 32'h22, 32'h22);
    drive(1, 6, 32'h66, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 1, 6, 6, 0);
    step();
    check_rsp("pre-reset", 1, 32'h66, 32'h66);
    rst = 1;
    drive(1, 7, 32'h77, 1, 6, 6, 0);
    step();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check_rsp("mid reset", 0, 0, 0);
    check("mid reset req_ready", 32'(req_ready), 1);
    drive(0, 0, 0, 1, 6, 7, 1);
    step();
    check_rsp("post reset read", 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Consumer end of the writeback path: holds the 32x32 general-purpose register bank.
- Accepts one write per cycle from the writeback data selector (memory / ALU / PC-link value already chosen upstream).
- Serves decode-stage operand reads over a valid/ready handshake.
- Returns both operands from a registered output stage with one-cycle latency and stall-safe holding.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register index width; bank depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is an ordinary register

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  destination register index
- wr_data  in  DATA_W  writeback value from the write-data selector
- req_valid  in  1  decode presents an operand read request
- req_ready  out  1  block can accept a request this cycle
- rs_addr  in  ADDR_W  first source index
- rt_addr  in  ADDR_W  second source index
- rsp_valid  out  1  rs_data/rt_data valid
- rsp_ready  in  1  consumer accepts the response
- rs_data  out  DATA_W  first operand
- rt_data  out  DATA_W  second operand

Behaviour:
- Reset, synchronous and active-high: all bank entries = 0, rsp_valid = 0, rs_data = 0, rt_data = 0. req_ready reads 1 in the cycle after reset deasserts.
- Write: on a clk edge with wr_en=1, bank[wr_addr] <= wr_data. With ZERO_REG=1, writes to index 0 are dropped.
- Handshake state, a single flag rsp_valid (EMPTY / FULL):
  - req_ready = !rsp_valid || rsp_ready, combinational.
  - Accept = req_valid && req_ready. On accept, the next cycle has rsp_valid=1 and the operands captured.
  - Latency is exactly one cycle.
  - rsp_ready=1 with no accept in the same cycle: rsp_valid <= 0. rs_data/rt_data keep their last value.
  - FULL and rsp_ready=0: outputs are held stable, and the request is not accepted.
  - Accept and drain in the same cycle: back-to-back operation, full throughput.
- Operand capture: rs_data <= value(rs_addr), rt_data <= value(rt_addr).
  - value(a) = 0 if ZERO_REG && a==0.
  - Otherwise, wr_data if the bypass applies (see Optional Feature).
  - Otherwise, bank[a] as it was before this edge.
- rs_addr == rt_addr is legal; both outputs return the same value.
- req_valid while FULL and rsp_ready=0: ignored. The requester must keep the request asserted, with addresses stable, until accepted.
- Reset mid-operation: a pending response is discarded (rsp_valid=0). Any write in the reset cycle is discarded.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined:
  - Same-cycle write-to-read forwarding: if wr_en && wr_addr==read address (and the address is not zero with ZERO_REG=1), the captured operand = wr_data.
  - Stall refresh: while FULL and rsp_ready=0, a write whose wr_addr matches the held rs or rt index updates that held output in place. The held indices are kept in internal registers for this purpose.
- Undefined:
  - A read captures the pre-edge bank contents only.
  - Held outputs never change while stalled.
  - Writeback-to-decode hazards must then be covered by upstream stall logic.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, the ZERO_REG index constant, and the response-flag encoding (RSP_EMPTY=0, RSP_FULL=1).
- One natural sub-module, regfile_bank: storage array with one synchronous write port and two asynchronous read ports, with zero-register masking.
- Handshake, bypass and output registers live in the top.

Test Plan:
- Reset, then read r3, r7 with rsp_ready=1 -> next cycle rsp_valid=1, rs_data=0, rt_data=0; req_ready stays 1.
- Write r5=0xDEADBEEF; next cycle read rs=r5, rt=r0 -> rs_data=0xDEADBEEF, rt_data=0 (ZERO_REG=1). Then write r0=0x1234 and read r0 -> 0.
- Same-cycle wr_en r9=0xA5A5A5A5 and read r9:
  - With RF_BYPASS_EN -> rs_data=0xA5A5A5A5.
  - Without it -> old r9 (0); a re-read a cycle later -> 0xA5A5A5A5.
- Stall: accept a read of r2 (=0x11), hold rsp_ready=0 for 3 cycles, present a new request, write r2=0x22 in cycle 2 ->
  - req_ready=0 throughout; the new request is not accepted.
  - rs_data becomes 0x22 with RF_BYPASS_EN, stays 0x11 without it.
  - Release rsp_ready -> the held response drains, then the new request is accepted.
- Back-to-back: 8 consecutive requests r1..r8 (preloaded 1..8) with rsp_ready=1 -> 8 consecutive responses rs_data=1..8, no bubbles.
- Assert rst while FULL with rsp_ready=0 -> next cycle rsp_valid=0, rs_data=rt_data=0, and a read of a previously written register returns 0.
